// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: access-size encoding and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mau_pkg;

  // Access size as log2 of the byte count.
  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mau_state_t;

endpackage

// File: rtl/BusDriver.sv
// Tri-state driver for the shared memory data bus.
// Latency: combinational.
// Backpressure: none; drives bus whenever en=1, releases it to 'z otherwise.
//   en   in     1   drive enable
//   data in     W   value placed on the bus
//   bus  inout  W   shared tri-state data bus
module BusDriver #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] data,
  inout  wire  [W-1:0] bus
);

  assign bus = en ? data : {W{1'bz}};

endmodule

// File: rtl/mau_lane_align.sv
// Byte-lane alignment: extracts/extends a load field and merges store lanes into read data.
// Latency: combinational.
// Backpressure: none.
//   rd     in  DATA_W  word read from the bus
//   wd     in  DATA_W  right-justified store data
//   off    in  OFF_W   byte offset of the access (already size-aligned)
//   size   in  SIZE_W  log2 of access bytes
//   uns    in  1       zero-extend when 1, sign-extend when 0
//   ext    out DATA_W  extended load result
//   merged out DATA_W  rd with the addressed lanes replaced by wd
module mau_lane_align
  import mau_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES),
  localparam int SIZE_W = $clog2(OFF_W + 1)
) (
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  input  logic [OFF_W-1:0]  off,
  input  logic [SIZE_W-1:0] size,
  input  logic              uns,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);

  logic [OFF_W:0]    nbytes;
  logic [OFF_W:0]    lo;
  logic [OFF_W:0]    hi;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] wd_sh;
  logic              sgn;

  always_comb begin
    nbytes = (OFF_W+1)'(1) << size;
    lo     = {1'b0, off};
    hi     = lo + nbytes;
    rd_sh  = rd >> {off, 3'b000};
    wd_sh  = wd << {off, 3'b000};
    ext    = '0;
    merged = '0;

    // Sign bit is the top bit of the last byte of the field.
    sgn = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if ((OFF_W+1)'(b) == nbytes - (OFF_W+1)'(1)) sgn = rd_sh[8*b+7];
    end

    for (int b = 0; b < BYTES; b++) begin
      if ((OFF_W+1)'(b) < nbytes) ext[8*b +: 8] = rd_sh[8*b +: 8];
      else                         ext[8*b +: 8] = {8{sgn & ~uns}};

      if (((OFF_W+1)'(b) >= lo) && ((OFF_W+1)'(b) < hi)) merged[8*b +: 8] = wd_sh[8*b +: 8];
      else                                                merged[8*b +: 8] = rd[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine on a shared tri-state bus: sized loads with extension, RMW sub-word stores.
// Latency: load/full store done 2 cycles after accept, sub-word store 3; +1 per mem_ready wait cycle.
// Backpressure: req ignored while busy; mem_ready stalls the bus phase, TIMEOUT waits abort with err.
// Option: define MAU_MISALIGN_TRAP_EN to fail misaligned accesses instead of rounding the offset down.
// Ports: clock/resetn; req/we/size/un_signed/addr/wdata request; busy/done/err/rdata response;
//        bus/read/write/address/mem_ready memory side.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int BYTES   = DATA_W / 8,
  localparam int OFF_W   = $clog2(BYTES),
  localparam int SIZE_W  = $clog2(OFF_W + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic              we,
  input  logic [SIZE_W-1:0] size,
  input  logic              un_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] bus,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  input  logic              mem_ready
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mau_state_t        state_q, state_d;
  logic [SIZE_W-1:0] size_q;
  logic              we_q;
  logic              uns_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept, rd_hit, tmo;
  logic [OFF_W-1:0]  in_off, in_mask, acc_off;
  logic              illegal, sub_word, fault, tmo_now;
  logic [DATA_W-1:0] ext, merged;

  // Request decode, evaluated only when accepted in IDLE.
  always_comb begin
    in_off   = addr[OFF_W-1:0];
    in_mask  = OFF_W'(((OFF_W+1)'(1) << size) - (OFF_W+1)'(1));
    illegal  = size > SIZE_W'(OFF_W);
    sub_word = size != SIZE_W'(OFF_W);
`ifdef MAU_MISALIGN_TRAP_EN
    fault    = illegal | ((in_off & in_mask) != '0);
    acc_off  = in_off;
`else
    fault    = illegal;
    acc_off  = in_off & ~in_mask;
`endif
    // Abort on the cycle that would bring the wait count up to TIMEOUT.
    tmo_now  = (TIMEOUT != 0) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    accept  = 1'b0;
    rd_hit  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          accept = 1'b1;
          if (fault)                state_d = DONE;
          else if (!we || sub_word) state_d = READ;
          else                      state_d = WRITE;
        end
      end
      READ: begin
        read = 1'b1;
        if (mem_ready) begin
          rd_hit  = 1'b1;
          state_d = we_q ? WRITE : DONE;
        end else if (tmo_now) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        write = 1'b1;
        if (mem_ready) begin
          state_d = DONE;
        end else if (tmo_now) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      address <= '0;
    end else begin
      if (accept) begin
        size_q  <= size;
        we_q    <= we;
        uns_q   <= un_signed;
        off_q   <= acc_off;
        wdata_q <= wdata;
        cnt_q   <= '0;
        err     <= fault;
        address <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (we && !sub_word) buf_q <= wdata;
      end else if (rd_hit) begin
        // Counter restarts for the write phase of an RMW.
        cnt_q <= '0;
        if (we_q) buf_q <= merged;
        else      rdata <= ext;
      end else if (tmo) begin
        err <= 1'b1;
      end else if ((read || write) && !mem_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  mau_lane_align #(.DATA_W(DATA_W)) u_align (
    .rd     (bus),
    .wd     (wdata_q),
    .off    (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .ext    (ext),
    .merged (merged)
  );

  BusDriver #(.W(DATA_W)) u_drv (
    .en   (write),
    .data (buf_q),
    .bus  (bus)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of expected completions.
// Latency: n/a.
// Backpressure: memory model stalls mem_ready by a per-access delay (-1 = never ready).
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clock     = 1'b0;
  logic        resetn    = 1'b0;
  logic        req       = 1'b0;
  logic        we        = 1'b0;
  logic [1:0]  size      = 2'd0;
  logic        un_signed = 1'b0;
  logic [31:0] addr      = 32'h0;
  logic [31:0] wdata     = 32'h0;
  logic        mem_ready = 1'b0;
  logic        busy, done, err, read, write;
  logic [31:0] rdata, address;
  wire  [31:0] bus;
  logic [31:0] mem_word  = 32'h0;

  // Memory answers reads by driving the bus while the read strobe is high.
  assign bus = read ? mem_word : 32'hzzzz_zzzz;

  always #5 clock = ~clock;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .we        (we),
    .size      (size),
    .un_signed (un_signed),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus       (bus),
    .read      (read),
    .write     (write),
    .address   (address),
    .mem_ready (mem_ready)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] wr_dat;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic bus_free();
    return (bus === 32'hzzzz_zzzz) || (bus === 32'h0);
  endfunction

  function automatic logic [1:0] eff_off(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return a[1:0];
      2'd1:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
    logic [1:0]  o;
    logic [7:0]  b;
    logic [15:0] h;
    o = eff_off(sz, a);
    case (sz)
      2'd0: begin
        b = w[8*o +: 8];
        return u ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        h = w[8*o +: 16];
        return u ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r;
    logic [1:0]  o;
    r = w;
    o = eff_off(sz, a);
    case (sz)
      2'd0:    r[8*o +: 8]  = wd[7:0];
      2'd1:    r[8*o +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // One access: push expectation, drive req for one cycle, run the memory model until done.
  task automatic run_access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                            input int delay, input logic poke);
    exp_t        e;
    exp_t        g;
    int          cyc, rd_c, wr_c, both_c, phase;
    logic [1:0]  prev;
    logic [31:0] wr_seen;
    logic        got;

    e.tag    = tag;
    e.err    = 1'b0;
    e.rdata  = last_rdata;
    e.wr_dat = 32'h0;
    e.addr   = {a[31:2], 2'b00};
    if (is_fault(sz, a)) begin
      e.err = 1'b1; e.lat = 1; e.rd_cyc = 0; e.wr_cyc = 0;
    end else if (!w) begin
      e.wr_cyc = 0;
      if (delay < 0) begin
        e.err = 1'b1; e.rd_cyc = 15; e.lat = 16;
      end else begin
        e.rd_cyc = delay + 1; e.lat = delay + 2; e.rdata = ld_model(mw, sz, u, a);
      end
    end else if (sz == 2'd2) begin
      e.rd_cyc = 0; e.wr_cyc = delay + 1; e.lat = delay + 2; e.wr_dat = wd;
    end else begin
      e.rd_cyc = delay + 1; e.wr_cyc = delay + 1; e.lat = 2 * delay + 3;
      e.wr_dat = st_model(mw, sz, a, wd);
    end
    last_rdata = e.rdata;
    sb.push_back(e);

    mem_word = mw; req = 1'b1; we = w; size = sz; un_signed = u; addr = a; wdata = wd;
    @(posedge clock);
    #1 req = 1'b0;

    cyc = 0; rd_c = 0; wr_c = 0; both_c = 0; phase = 0; prev = 2'b00; got = 1'b0; wr_seen = 32'h0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (poke) begin
        req  = (cyc == 1);
        addr = 32'h0000_0777;
      end
      if (read)          rd_c++;
      if (write)         begin wr_c++; wr_seen = bus; end
      if (read && write) both_c++;
      if (done) begin
        got = 1'b1;
        g = sb.pop_front();
        chk({g.tag, ".lat"},    32'(cyc),    32'(g.lat));
        chk({g.tag, ".err"},    32'(err),    32'(g.err));
        chk({g.tag, ".rdata"},  rdata,       g.rdata);
        chk({g.tag, ".rd_cyc"}, 32'(rd_c),   32'(g.rd_cyc));
        chk({g.tag, ".wr_cyc"}, 32'(wr_c),   32'(g.wr_cyc));
        chk({g.tag, ".rw_exc"}, 32'(both_c), 32'd0);
        chk({g.tag, ".addr"},   address,     g.addr);
        if (g.wr_cyc > 0) chk({g.tag, ".wr_dat"}, wr_seen, g.wr_dat);
      end
      if (read || write) begin
        if ({read, write} != prev) phase = 0;
        mem_ready = (delay >= 0) && (phase >= delay);
        phase++;
      end else begin
        mem_ready = 1'b0;
      end
      prev = {read, write};
    end
    mem_ready = 1'b0;
    req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s.no_done: observed no done expected done within 40 cycles", tag);
      void'(sb.pop_front());
    end
    @(negedge clock);
    chk({tag, ".idle"}, 32'(busy),       32'd0);
    chk({tag, ".free"}, 32'(bus_free()), 32'd1);
  endtask

  logic seen_done;

  initial begin
    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst0.busy",    32'(busy),       32'd0);
    chk("rst0.done",    32'(done),       32'd0);
    chk("rst0.err",     32'(err),        32'd0);
    chk("rst0.read",    32'(read),       32'd0);
    chk("rst0.write",   32'(write),      32'd0);
    chk("rst0.rdata",   rdata,           32'h0);
    chk("rst0.address", address,         32'h0);
    chk("rst0.bus",     32'(bus_free()), 32'd1);
    resetn = 1'b1;
    @(negedge clock);

    run_access("ld_byte",   1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0,    32'h80FF1234, 0,  1'b0);
    chk("ld_byte.const", rdata, 32'hFFFFFF80);
    run_access("st_half",   1'b1, SIZE_HALF, 1'b0, 32'h202, 32'hBEEF, 32'h11223344, 0,  1'b0);
    run_access("ld_wait",   1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0,    32'hCAFEF00D, 3,  1'b0);
    run_access("ld_tmo",    1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0,    32'h01020304, -1, 1'b0);
    run_access("ld_mis",    1'b0, SIZE_HALF, 1'b0, 32'h101, 32'h0,    32'h87654321, 0,  1'b0);
    run_access("ld_ill",    1'b0, SIZE_DWORD,1'b0, 32'h100, 32'h0,    32'h55555555, 0,  1'b0);
    run_access("st_word",   1'b1, SIZE_WORD, 1'b0, 32'h400, 32'h12345678, 32'h0,    1,  1'b0);
    run_access("st_byte_p", 1'b1, SIZE_BYTE, 1'b0, 32'h401, 32'h000000AB, 32'hFFFFFFFF, 1, 1'b1);
    run_access("ld_half_u", 1'b0, SIZE_HALF, 1'b1, 32'h602, 32'h0,    32'h9A7B5C8E, 2,  1'b1);

    for (int sz = 0; sz < 2; sz++) begin
      for (int o = 0; o < 4; o++) begin
        for (int u = 0; u < 2; u++) begin
          run_access($sformatf("ld_s%0d_o%0d_u%0d", sz, o, u), 1'b0, 2'(sz), 1'(u),
                     32'h800 + 32'(o), 32'h0, 32'h9A7B5C8E, 0, 1'b0);
        end
      end
    end

    // Reset while a full-word store waits on mem_ready.
    mem_word = 32'h0; req = 1'b1; we = 1'b1; size = SIZE_WORD; addr = 32'h500; wdata = 32'hA5A55A5A;
    @(posedge clock);
    #1 req = 1'b0;
    repeat (3) @(negedge clock);
    chk("rstw.write_before", 32'(write), 32'd1);
    chk("rstw.bus_before",   bus,        32'hA5A55A5A);
    #2 resetn = 1'b0;
    #1;
    chk("rstw.write", 32'(write),      32'd0);
    chk("rstw.bus",   32'(bus_free()), 32'd1);
    chk("rstw.busy",  32'(busy),       32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done) seen_done = 1'b1;
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done) seen_done = 1'b1;
    end
    chk("rstw.no_done", 32'(seen_done), 32'd0);
    chk("rstw.rdata",   rdata,          32'h0);
    last_rdata = 32'h0;
    run_access("after_rst", 1'b0, SIZE_BYTE, 1'b1, 32'h703, 32'h0, 32'hC3000000, 0, 1'b0);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
